// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and muldiv_unit.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] wr_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, wr_hi, wr_lo, wr_data,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, wr_hi, wr_lo, wr_data,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one iteration per cycle, WIDTH iterations.
// Optional MADD/MADDU accumulate ops are enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc, base, res_p0, res_p1;
   logic [WIDTH-1:0]   opnd, raw_a, hi, lo;
   logic [WIDTH-1:0]   mag_a, mag_b, hi_wr, lo_wr;
   logic               is_div, is_madd, neg_res, neg_rem, div0;
   logic               busy, done, vld_p1;
   logic               accept, wr_ok, neg_a, neg_b, op_is_div;

   function automatic logic op_valid(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
      return op < 3'd6;
`else
      return op < 3'd4;
`endif
   endfunction

   function automatic logic [WIDTH-1:0] negate_if(input logic signed [WIDTH-1:0] x,
                                                   input logic neg);
      return neg ? -x : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] negate_wide_if(input logic signed [2*WIDTH-1:0] x,
                                                         input logic neg);
      return neg ? -x : x;
   endfunction

   // Shift-add: upper half accumulates the multiplicand, multiplier bits leave through bit 0.
   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc_in,
                                                   input logic [WIDTH-1:0]   mcand);
      logic [WIDTH:0] sum;
      sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{acc_in[0]}}};
      return {sum, acc_in[WIDTH-1:1]};
   endfunction

   // Restoring divide: acc holds {remainder, dividend/quotient}.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc_in,
                                                   input logic [WIDTH-1:0]   dvsr);
      logic [WIDTH:0] shifted, diff;
      shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
      diff    = shifted - {1'b0, dvsr};
      if (!diff[WIDTH])
         return {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      else
         return {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
   endfunction

   assign wr_ok     = (state == IDLE) && !busy;
   assign op_is_div = (bus.op[2:1] == 2'b01);

   always_comb begin
      neg_a = bus.op[0] && bus.a[WIDTH-1];
      neg_b = bus.op[0] && bus.b[WIDTH-1];
      mag_a = negate_if(bus.a, neg_a);
      mag_b = negate_if(bus.b, neg_b);
      hi_wr = (wr_ok && bus.wr_hi) ? bus.wr_data : hi;
      lo_wr = (wr_ok && bus.wr_lo) ? bus.wr_data : lo;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start && !busy && op_valid(bus.op)) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Sign fixup of the raw iteration result, registered in FIX.
   always_comb begin
      res_p0 = '0;
      if (is_div) begin
         if (div0)
            res_p0 = {raw_a, {WIDTH{1'b1}}};
         else
            res_p0 = {negate_if(acc[2*WIDTH-1:WIDTH], neg_rem),
                      negate_if(acc[WIDTH-1:0], neg_res)};
      end else begin
         res_p0 = negate_wide_if(acc, neg_res);
         if (is_madd) res_p0 = base + res_p0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         vld_p1  <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         base    <= '0;
         res_p1  <= '0;
         opnd    <= '0;
         raw_a   <= '0;
         is_div  <= 1'b0;
         is_madd <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         div0    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         busy   <= (state != IDLE);
         vld_p1 <= (state == FIX);
         done   <= vld_p1;
         if (accept) begin
            cnt     <= '0;
            is_div  <= op_is_div;
            is_madd <= bus.op[2];
            neg_res <= neg_a ^ neg_b;
            neg_rem <= neg_a;
            div0    <= op_is_div && (bus.b == '0);
            raw_a   <= bus.a;
            base    <= {hi_wr, lo_wr};
            if (op_is_div) begin
               acc  <= {{WIDTH{1'b0}}, mag_a};
               opnd <= mag_b;
            end else begin
               acc  <= {{WIDTH{1'b0}}, mag_b};
               opnd <= mag_a;
            end
         end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            acc <= is_div ? div_step(acc, opnd) : mul_step(acc, opnd);
         end
         if (state == FIX) res_p1 <= res_p0;
         // Commit stage: the result wins; writes are only open while fully idle.
         if (vld_p1) begin
            hi <= res_p1[2*WIDTH-1:WIDTH];
            lo <= res_p1[WIDTH-1:0];
         end else begin
            hi <= hi_wr;
            lo <= lo_wr;
         end
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.hi   = hi;
   assign bus.lo   = lo;
endmodule
